// File: rtl/buffer_tile_reader.sv
// Read-side master for buffer_file: drains one whole buffer tile by tile and serialises each
// tile onto a byte stream with valid/ready backpressure.
module buffer_tile_reader #(
  parameter int unsigned BUFFER_WIDTH = 1024,
  parameter int unsigned BUFFER_COUNT = 2,
  parameter int unsigned TILE_WIDTH   = 256,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned TILE_SIZE    = 32,
  localparam int unsigned SelW = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [SelW-1:0]                 buf_sel_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic                            read_enable_o,
  output logic [SelW-1:0]                 read_buffer_o,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0] read_data_i,
  input  logic                            reading_done_i,
  output logic [DATA_WIDTH-1:0]           out_data_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            out_last_o
);

  localparam int unsigned TILE_COUNT = BUFFER_WIDTH / TILE_WIDTH;
  localparam int unsigned TcW = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;
  localparam int unsigned BcW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam logic [TcW-1:0] TileLast = TcW'(TILE_COUNT - 1);
  localparam logic [BcW-1:0] ByteLast = BcW'(TILE_SIZE - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StReq    = 3'd1;
  localparam logic [2:0] StCapt   = 3'd2;
  localparam logic [2:0] StStream = 3'd3;
  localparam logic [2:0] StFin    = 3'd4;

  logic [2:0]                                state_q, state_d;
  logic [TcW-1:0]                            tile_cnt_q, tile_cnt_d;
  logic [BcW-1:0]                            byte_cnt_q, byte_cnt_d;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0]      tile_q, tile_d;
  logic [SelW-1:0]                           buf_q, buf_d;
  logic                                      err_q, err_d;

  logic tile_last, byte_last, streaming;

  assign tile_last = (tile_cnt_q == TileLast);
  assign byte_last = (byte_cnt_q == ByteLast);
  assign streaming = (state_q == StStream);

  always_comb begin
    state_d    = state_q;
    tile_cnt_d = tile_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tile_d     = tile_q;
    buf_d      = buf_q;
    err_d      = err_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          buf_d      = buf_sel_i;
          err_d      = 1'b0;
          tile_cnt_d = '0;
          state_d    = StReq;
        end
      end
      StReq: state_d = StCapt;
      StCapt: begin
        tile_d     = read_data_i;
        byte_cnt_d = '0;
        // reading_done must coincide exactly with the final tile; the drain continues anyway
        if (reading_done_i != tile_last) begin
          err_d = 1'b1;
        end
        state_d = StStream;
      end
      StStream: begin
        if (out_ready_i) begin
          if (byte_last) begin
            byte_cnt_d = '0;
            if (tile_last) begin
              state_d = StFin;
            end else begin
              tile_cnt_d = tile_cnt_q + TcW'(1);
              state_d    = StReq;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BcW'(1);
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      tile_cnt_q <= '0;
      byte_cnt_q <= '0;
      tile_q     <= '0;
      buf_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_cnt_q <= tile_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tile_q     <= tile_d;
      buf_q      <= buf_d;
      err_q      <= err_d;
    end
  end

  // All outputs decode registered state only, so out_ready never reaches out_valid.
  always_comb begin
    busy_o        = (state_q == StReq) || (state_q == StCapt) || streaming;
    done_o        = (state_q == StFin);
    err_o         = err_q;
    read_enable_o = (state_q == StReq);
    read_buffer_o = buf_q;
    out_valid_o   = streaming;
    out_data_o    = streaming ? tile_q[byte_cnt_q] : '0;
    out_last_o    = streaming && byte_last && tile_last;
  end

endmodule
